fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_sync_param_dpram.sv | 37 +++
 rtl/fifo_sync_param.sv | 102 ++++++++++
 tb/tb_fifo_sync_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, count-width helper and the
// threshold legality rule used by every FIFO variant.
package fifo_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 3;

   // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
   function automatic int count_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic bit thresholds_ok(input int ae_level, input int af_level, input int depth);
      return (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/fifo_sync_param_dpram.sv
// Generic dual-port RAM: synchronous write port and registered read port.
// Storage is never cleared; only the read register has a reset.
module dpram_param #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Read register holds its value when no read is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: pointer/occupancy controller around dpram_param,
// with registered flags decoded from the count and sticky error bits.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CW    = count_w(ADDR_W);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   if (!thresholds_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_thresholds
      $error("fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_valid;
   logic              r_overflow;
   logic              r_underflow;

   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;

   // Flags come from the count register only, so no input reaches an output.
   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);

   // Reset blocks the RAM ports too, so an in-flight write or read is dropped.
   assign w_push_ok = wr_en & ~w_full  & ~reset;
   assign w_pop_ok  = rd_en & ~w_empty & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_valid     <= w_pop_ok;
         r_overflow  <= r_overflow  | (wr_en & w_full);
         r_underflow <= r_underflow | (rd_en & w_empty);
      end
   end

   dpram_param #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (w_push_ok),
      .waddr (r_wr_ptr),
      .wdata (data_in),
      .re    (w_pop_ok),
      .raddr (r_rd_ptr),
      .rdata (data_out)
   );

   assign valid_out    = r_valid;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= AF_C);
   assign almost_empty = (r_count <= AE_C);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (8-bit x 8, AF=6, AE=2).
// Inputs change and outputs are checked on the falling clock edge.
module tb_fifo_sync_param;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  fifo_sync_param #(
    .DATA_W   (8),
    .ADDR_W   (3),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle: inputs applied at negedge, outputs observed at the next negedge
  task automatic cyc(input logic rst, input logic wr, input logic [7:0] din, input logic rd);
    reset   = rst;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    @(negedge clk);
    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic check_pop(input string tag);
    exp_word = exp_q.pop_front();
    check({tag, "_data"}, data_out, exp_word);
    check({tag, "_valid"}, valid_out, 1);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    @(negedge clk);

    // reset then idle
    cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // fill with 0x11..0x18, watching the threshold flags
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'(8'h10 + i), 0);
      exp_q.push_back(8'(8'h10 + i));
      check("fill_count", count, i);
      check("fill_ae", almost_empty, (i <= 2));
      check("fill_af", almost_full, (i >= 6));
      check("fill_full", full, (i == 8));
      check("fill_empty", empty, 0);
      check("fill_valid", valid_out, 0);
    end

    // drain in order
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 8'h00, 1);
      check_pop("drain");
      check("drain_count", count, 8 - i);
    end
    cyc(0, 0, 8'h00, 0);
    check("drain_valid_low", valid_out, 0);
    check("drain_empty", empty, 1);
    check("drain_data_hold", data_out, 8'h18);

    // refill, then push while full
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'(8'h20 + i), 0);
      exp_q.push_back(8'(8'h20 + i));
    end
    check("refill_full", full, 1);
    cyc(0, 1, 8'h99, 0);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    cyc(0, 0, 8'h00, 0);
    check("ovf_sticky", overflow, 1);

    // push + pop while full: only the pop goes through
    cyc(0, 1, 8'h77, 1);
    check_pop("fullpp");
    check("fullpp_count", count, 7);
    check("fullpp_ovf", overflow, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 8'h00, 1);
      check_pop("fullpp_drain");
    end
    check("fullpp_empty", empty, 1);
    cyc(0, 0, 8'h00, 0);

    // pop while empty
    cyc(0, 0, 8'h00, 1);
    check("udf_flag", underflow, 1);
    check("udf_valid", valid_out, 0);
    check("udf_data_hold", data_out, 8'h28);
    check("udf_count", count, 0);

    // push + pop while empty: only the push goes through, no bypass
    cyc(0, 1, 8'h42, 1);
    exp_q.push_back(8'h42);
    check("emptypp_count", count, 1);
    check("emptypp_valid", valid_out, 0);
    check("emptypp_data", data_out, 8'h28);
    cyc(0, 0, 8'h00, 1);
    check_pop("emptypp_pop");
    check("emptypp_count2", count, 0);
    check("emptypp_udf", underflow, 1);

    // clear the sticky errors before the steady-state run
    cyc(1, 0, 8'h00, 0);
    check("clr_ovf", overflow, 0);
    check("clr_udf", underflow, 0);

    // half full, 20 cycles of simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'(8'h50 + i), 0);
      exp_q.push_back(8'(8'h50 + i));
    end
    check("half_count", count, 4);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 8'(8'h54 + k), 1);
      exp_q.push_back(8'(8'h54 + k));
      check_pop("steady");
      check("steady_count", count, 4);
    end
    check("steady_ovf", overflow, 0);
    check("steady_udf", underflow, 0);

    // reset mid-stream with count=5 and a read requested
    cyc(0, 1, 8'h68, 0);
    check("pre_rst_count", count, 5);
    cyc(1, 0, 8'h00, 1);
    exp_q.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_udf", underflow, 0);

    // round trip after reset
    cyc(0, 1, 8'hA5, 0);
    exp_q.push_back(8'hA5);
    check("post_rst_count", count, 1);
    cyc(0, 0, 8'h00, 1);
    check_pop("post_rst");
    check("post_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
